// File: rtl/psola_pkg.sv
// psola_pkg: shared constants and types for the PSOLA output path
package psola_pkg;
  localparam int FRACTION_WIDTH = 11;
  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;
  typedef enum logic {PRIMING, RUNNING} out_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: count-based synchronous FIFO with registered read data
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [AW:0] count_d, count_q;
  logic [WIDTH-1:0] rd_data_d, rd_data_q;
  logic do_push, do_pop;
  // a pop frees the slot the same cycle, so a push into a full FIFO is accepted alongside it
  always_comb begin
    do_pop = pop && (count_q != '0);
    do_push = push && (count_q != FULL_CNT || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    rd_data_d = do_pop ? mem_q[rd_ptr_q] : rd_data_q;
  end
  // storage has no reset; the pointers alone define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
  // pointer, occupancy and read-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign pop_data = rd_data_q;
  assign count = count_q;
  assign full = count_q == FULL_CNT;
  assign empty = count_q == '0;
endmodule

// File: rtl/psola_output_stage.sv
// psola_output_stage: rescale/saturate PSOLA samples, buffer them and release one per audio tick; PWM DAC enabled by PSOLA_OUT_PWM_EN
module psola_output_stage #(
  parameter int FRACTION_WIDTH = psola_pkg::FRACTION_WIDTH,
  parameter int FIFO_DEPTH = 64,
  parameter int PREFILL = 32,
  parameter int SAMPLE_PERIOD = 2268
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [31:0]                   psola_in,
  input  logic                          psola_valid_in,
  output logic [15:0]                   audio_out,
  output logic                          audio_valid_out,
  output logic                          pwm_out,
  output logic                          overflow_out,
  output logic                          underflow_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);
  import psola_pkg::*;
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
  logic signed [31:0] shifted;
  logic [15:0] conv_d, conv_q;
  logic conv_valid_d, conv_valid_q;
  logic [TW-1:0] tick_cnt_d, tick_cnt_q;
  logic tick, pop, fifo_full, fifo_empty;
  out_state_e state_d, state_q;
  logic audio_valid_d, audio_valid_q;
  logic overflow_d, overflow_q, underflow_d, underflow_q;
  // conversion, tick generation and playback control
  always_comb begin
    shifted = $signed(psola_in) >>> FRACTION_WIDTH;
    conv_d = shifted > SAMPLE_MAX ? 16'h7fff : shifted < SAMPLE_MIN ? 16'h8000 : shifted[15:0];
    conv_valid_d = psola_valid_in;
    tick = tick_cnt_q == TICK_LAST;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    pop = tick && state_q == RUNNING && !fifo_empty;
    state_d = (state_q == PRIMING && fifo_count_out >= PREFILL) ? RUNNING : state_q;
    audio_valid_d = tick && state_q == RUNNING;
    overflow_d = overflow_q | (conv_valid_q && fifo_full && !pop);
    underflow_d = underflow_q | (tick && state_q == RUNNING && fifo_empty);
  end
  // playback state machine with its registered strobes and sticky flags
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      conv_q <= '0;
      conv_valid_q <= 1'b0;
      tick_cnt_q <= '0;
      state_q <= PRIMING;
      audio_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      conv_q <= conv_d;
      conv_valid_q <= conv_valid_d;
      tick_cnt_q <= tick_cnt_d;
      state_q <= state_d;
      audio_valid_q <= audio_valid_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_in),
    .rst_n(rst_n_in),
    .push(conv_valid_q),
    .push_data(conv_q),
    .pop(pop),
    .pop_data(audio_out),
    .count(fifo_count_out),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign audio_valid_out = audio_valid_q;
  assign overflow_out = overflow_q;
  assign underflow_out = underflow_q;
`ifdef PSOLA_OUT_PWM_EN
  logic [7:0] pwm_cnt_d, pwm_cnt_q, duty_d, duty_q;
  logic pwm_d, pwm_q;
  // duty only changes at counter wrap so each PWM period is glitch-free; offset binary maps 0 to mid-scale
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    duty_d = &pwm_cnt_q ? {~audio_out[15], audio_out[14:8]} : duty_q;
    pwm_d = pwm_cnt_q < duty_q;
  end
  // PWM counter, duty and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pwm_cnt_q <= '0;
      duty_q <= 8'h80;
      pwm_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q <= duty_d;
      pwm_q <= pwm_d;
    end
  end
  assign pwm_out = pwm_q;
`else
  assign pwm_out = 1'b0;
`endif
endmodule

// File: tb/tb_psola_output_stage.sv
// tb_psola_output_stage: directed self-checking bench for psola_output_stage
module tb_psola_output_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] psola_in = '0;
  logic psola_valid = 1'b0;
  logic [15:0] audio_out;
  logic audio_valid, pwm, ovf, unf;
  logic [6:0] count;
  int compared = 0;
  int mismatched = 0;
  int acc;
  logic [15:0] exp_tab [32];

  always #5 clk = ~clk;

  psola_output_stage #(
    .FRACTION_WIDTH(11),
    .FIFO_DEPTH(64),
    .PREFILL(32),
    .SAMPLE_PERIOD(200)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .psola_in(psola_in),
    .psola_valid_in(psola_valid),
    .audio_out(audio_out),
    .audio_valid_out(audio_valid),
    .pwm_out(pwm),
    .overflow_out(ovf),
    .underflow_out(unf),
    .fifo_count_out(count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] d);
    psola_in = d;
    psola_valid = 1'b1;
    @(negedge clk);
    psola_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    psola_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (audio_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, audio_valid}, 32'd1);
  endtask

  initial begin
    exp_tab[0] = 16'd8;
    exp_tab[1] = 16'h7fff;
    exp_tab[2] = 16'hffff;
    exp_tab[3] = 16'h8000;
    for (int k = 4; k < 32; k++) exp_tab[k] = 16'(k);

    repeat (2) @(negedge clk);
    check("rst_audio", {16'b0, audio_out}, 32'd0);
    check("rst_valid", {31'b0, audio_valid}, 32'd0);
    check("rst_pwm", {31'b0, pwm}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_unf", {31'b0, unf}, 32'd0);
    check("rst_count", {25'b0, count}, 32'd0);
    rst_n = 1'b1;

    acc = 0;
    repeat (256) begin
      @(negedge clk);
      acc += int'(pwm);
    end
`ifdef PSOLA_OUT_PWM_EN
    check("pwm_duty_zero_input", 32'(acc), 32'd128);
`else
    check("pwm_tied_low", 32'(acc), 32'd0);
`endif

    do_reset();
    push(32'h0000_4000);
    push(32'h7FFF_FFFF);
    push(32'hFFFF_F800);
    push(32'h8000_0000);
    for (int k = 4; k < 31; k++) push(32'(k) << 11);
    @(negedge clk);
    check("prime_count31", {25'b0, count}, 32'd31);
    acc = 0;
    repeat (600) begin
      @(negedge clk);
      acc += int'(audio_valid);
    end
    check("prime_no_strobe", 32'(acc), 32'd0);
    check("prime_count_held", {25'b0, count}, 32'd31);
    push(32'(31) << 11);
    for (int k = 0; k < 32; k++) begin
      wait_strobe($sformatf("play_strobe_%0d", k));
      check($sformatf("play_sample_%0d", k), {16'b0, audio_out}, {16'b0, exp_tab[k]});
      if (k == 0) begin
        check("play_count_after_pop", {25'b0, count}, 32'd31);
        @(negedge clk);
        check("strobe_one_cycle", {31'b0, audio_valid}, 32'd0);
      end
    end
    check("drain_no_unf", {31'b0, unf}, 32'd0);
    check("drain_count0", {25'b0, count}, 32'd0);
    wait_strobe("unf_strobe");
    check("unf_hold_sample", {16'b0, audio_out}, 32'd31);
    check("unf_flag", {31'b0, unf}, 32'd1);
    wait_strobe("unf_strobe_continues");

    do_reset();
    for (int k = 0; k < 70; k++) push(32'(k) << 11);
    repeat (2) @(negedge clk);
    check("ovf_count64", {25'b0, count}, 32'd64);
    check("ovf_flag", {31'b0, ovf}, 32'd1);
    check("ovf_no_unf", {31'b0, unf}, 32'd0);
    for (int k = 0; k < 64; k++) begin
      wait_strobe($sformatf("ovf_strobe_%0d", k));
      check($sformatf("ovf_sample_%0d", k), {16'b0, audio_out}, 32'(k));
    end
    wait_strobe("ovf_tail_strobe");
    check("ovf_dropped_never_out", {16'b0, audio_out}, 32'd63);
    check("ovf_tail_unf", {31'b0, unf}, 32'd1);
    check("ovf_tail_count", {25'b0, count}, 32'd0);

    psola_in = 32'h0001_0000;
    psola_valid = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_audio", {16'b0, audio_out}, 32'd0);
    check("midrst_valid", {31'b0, audio_valid}, 32'd0);
    check("midrst_pwm", {31'b0, pwm}, 32'd0);
    check("midrst_ovf", {31'b0, ovf}, 32'd0);
    check("midrst_unf", {31'b0, unf}, 32'd0);
    check("midrst_count", {25'b0, count}, 32'd0);
    repeat (3) @(negedge clk);
    psola_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_inputs_ignored", {25'b0, count}, 32'd0);

    do_reset();
    for (int i = 1; i < 200; i++) begin
      psola_in = 32'(i) << 11;
      psola_valid = (i <= 64) || (i == 199);
      @(negedge clk);
    end
    psola_valid = 1'b0;
    check("full_before_tick", {25'b0, count}, 32'd64);
    @(negedge clk);
    check("full_pushpop_count", {25'b0, count}, 32'd64);
    check("full_pushpop_no_ovf", {31'b0, ovf}, 32'd0);
    check("full_pushpop_strobe", {31'b0, audio_valid}, 32'd1);
    check("full_pushpop_head", {16'b0, audio_out}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
